// File: rtl/washer_pkg.sv
// Purpose: shared types, mode codes and segment table for the washing-machine sequencer.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package washer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_WASH  = 3'd2,
        ST_RINSE = 3'd3,
        ST_DRAIN = 3'd4,
        ST_SPIN  = 3'd5,
        ST_DONE  = 3'd6
    } state_t;

    // FILL and DRAIN are shared by the wash and rinse segments; the phase says which.
    typedef enum logic {
        PH_WASH  = 1'b0,
        PH_RINSE = 1'b1
    } phase_t;

    // Destination of a stage transition.
    typedef struct packed {
        state_t st;
        phase_t ph;
    } hop_t;

    typedef struct packed {
        logic spin;
        logic rinse;
        logic wash;
    } seg_en_t;

    localparam logic [2:0] MODE_FULL       = 3'd0;
    localparam logic [2:0] MODE_WASH       = 3'd1;
    localparam logic [2:0] MODE_WASH_RINSE = 3'd2;
    localparam logic [2:0] MODE_RINSE_SPIN = 3'd3;
    localparam logic [2:0] MODE_RINSE      = 3'd4;
    localparam logic [2:0] MODE_SPIN       = 3'd5;
    localparam logic [2:0] MODE_LAST       = MODE_SPIN;
    localparam logic [1:0] WEIGHT_LAST     = 2'd2;

    localparam int         DRAIN_T_DEF = 2;
    localparam int         BUZZ_T_DEF  = 5;
    localparam logic [7:0] W_OFFSET    = 8'd3;

    function automatic seg_en_t seg_en(input logic [2:0] mode);
        case (mode)
            MODE_FULL:       return '{spin: 1'b1, rinse: 1'b1, wash: 1'b1};
            MODE_WASH:       return '{spin: 1'b0, rinse: 1'b0, wash: 1'b1};
            MODE_WASH_RINSE: return '{spin: 1'b0, rinse: 1'b1, wash: 1'b1};
            MODE_RINSE_SPIN: return '{spin: 1'b1, rinse: 1'b1, wash: 1'b0};
            MODE_RINSE:      return '{spin: 1'b0, rinse: 1'b1, wash: 1'b0};
            MODE_SPIN:       return '{spin: 1'b1, rinse: 1'b0, wash: 1'b0};
            default:         return '{spin: 1'b0, rinse: 1'b0, wash: 1'b0};
        endcase
    endfunction

endpackage

// File: rtl/wash_sequencer_if.sv
// Purpose: panel/actuator bundle between the sequencer (slave) and its driver (master).
// Latency: n/a (wires only).
// Backpressure: none; inputs are single-cycle pulses, outputs are levels.
// Ports: tick/start_pause/mode_next/weight_next in; running, lights, valves, buzzer,
//        mode, weight, stage_time, total_time out.
interface wash_sequencer_if;
    logic       tick;
    logic       start_pause;
    logic       mode_next;
    logic       weight_next;
    logic       running;
    logic       light_xi;
    logic       light_piao;
    logic       light_tuo;
    logic       valve_in;
    logic       valve_out;
    logic       buzzer;
    logic [2:0] mode;
    logic [1:0] weight;
    logic [7:0] stage_time;
    logic [7:0] total_time;

    modport slave (
        input  tick, start_pause, mode_next, weight_next,
        output running, light_xi, light_piao, light_tuo, valve_in, valve_out,
               buzzer, mode, weight, stage_time, total_time
    );

    modport master (
        output tick, start_pause, mode_next, weight_next,
        input  running, light_xi, light_piao, light_tuo, valve_in, valve_out,
               buzzer, mode, weight, stage_time, total_time
    );
endinterface

// File: rtl/stage_timer.sv
// Purpose: 8-bit loadable down-counter with enable, saturating at 0, plus last-tick flag.
// Latency: count updates one cycle after load/dec; o_last is combinational from the count.
// Backpressure: none; load has priority over decrement.
// Ports: clk, rst (async active-low), i_load/i_load_val, i_dec -> o_count, o_last.
module stage_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_load,
    input  logic [7:0] i_load_val,
    input  logic       i_dec,
    output logic [7:0] o_count,
    output logic       o_last
);
    logic [7:0] r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= 8'd0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != 8'd0)) begin
            r_count <= r_count - 8'd1;
        end
    end

    assign o_count = r_count;
    assign o_last  = (r_count == 8'd1);
endmodule

// File: rtl/wash_sequencer.sv
// Purpose: washing-machine program sequencer (fill/wash/rinse/drain/spin, pause, buzzer).
// Latency: every output is registered and reflects an input pulse one cycle later.
// Backpressure: none; start_pause beats tick in the same cycle, panel keys only act in IDLE.
// Ports: clk, rst (async active-low), bus (wash_sequencer_if.slave).
module wash_sequencer
    import washer_pkg::*;
#(
    parameter int DRAIN_T = DRAIN_T_DEF,
    parameter int BUZZ_T  = BUZZ_T_DEF
) (
    input  logic             clk,
    input  logic             rst,
    wash_sequencer_if.slave  bus
);
    state_t     r_state, w_state_nxt;
    phase_t     r_phase, w_phase_nxt;
    hop_t       w_hop;
    seg_en_t    w_en;
    logic       r_paused, w_paused_nxt;
    logic [2:0] r_mode, w_mode_nxt;
    logic [1:0] r_weight, w_weight_nxt;
    logic [7:0] r_total, w_total_nxt;
    logic [7:0] w_w, w_load_val, w_stage_time;
    logic       w_load, w_dec, w_last;

    logic r_running, r_light_xi, r_light_piao, r_light_tuo, r_valve_in, r_valve_out, r_buzzer;
    logic w_running_nxt, w_light_xi_nxt, w_light_piao_nxt, w_light_tuo_nxt;
    logic w_valve_in_nxt, w_valve_out_nxt, w_buzzer_nxt, w_active_nxt;

    function automatic logic [7:0] stage_len(input state_t s, input logic [7:0] w);
        case (s)
            ST_FILL:  return w;
            ST_WASH:  return w + w + w;
            ST_RINSE: return w + w;
            ST_DRAIN: return 8'(DRAIN_T);
            ST_SPIN:  return w;
            ST_DONE:  return 8'(BUZZ_T);
            default:  return 8'd0;
        endcase
    endfunction

    function automatic logic [7:0] total_len(input seg_en_t en, input logic [7:0] w);
        logic [7:0] sum;
        sum = 8'd0;
        if (en.wash)  sum = sum + (w << 2) + 8'(DRAIN_T);
        if (en.rinse) sum = sum + w + w + w + 8'(DRAIN_T);
        if (en.spin)  sum = sum + w;
        return sum;
    endfunction

    // First enabled segment in wash -> rinse -> spin order; nothing left means DONE.
    function automatic hop_t first_seg(input seg_en_t en);
        if (en.wash)       return '{st: ST_FILL, ph: PH_WASH};
        else if (en.rinse) return '{st: ST_FILL, ph: PH_RINSE};
        else if (en.spin)  return '{st: ST_SPIN, ph: PH_WASH};
        else               return '{st: ST_DONE, ph: PH_WASH};
    endfunction

    assign w_en = seg_en(r_mode);
    assign w_w  = {6'd0, r_weight} + W_OFFSET;

    stage_timer u_stage_timer (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .i_dec      (w_dec),
        .o_count    (w_stage_time),
        .o_last     (w_last)
    );

    // State register (plus the program registers that move with it).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= ST_IDLE;
            r_phase  <= PH_WASH;
            r_paused <= 1'b0;
            r_mode   <= MODE_FULL;
            r_weight <= 2'd0;
            r_total  <= 8'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_phase  <= w_phase_nxt;
            r_paused <= w_paused_nxt;
            r_mode   <= w_mode_nxt;
            r_weight <= w_weight_nxt;
            r_total  <= w_total_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt  = r_state;
        w_phase_nxt  = r_phase;
        w_paused_nxt = r_paused;
        w_mode_nxt   = r_mode;
        w_weight_nxt = r_weight;
        w_total_nxt  = r_total;
        w_load       = 1'b0;
        w_load_val   = 8'd0;
        w_dec        = 1'b0;
        w_hop        = '{st: ST_DONE, ph: PH_WASH};
        case (r_state)
            ST_IDLE: begin
                w_paused_nxt = 1'b0;
                if (bus.start_pause) begin
                    w_hop       = first_seg(w_en);
                    w_state_nxt = w_hop.st;
                    w_phase_nxt = w_hop.ph;
                    w_load      = 1'b1;
                    w_load_val  = stage_len(w_hop.st, w_w);
                    w_total_nxt = total_len(w_en, w_w);
                end else begin
                    if (bus.mode_next)
                        w_mode_nxt = (r_mode == MODE_LAST) ? MODE_FULL : r_mode + 3'd1;
                    if (bus.weight_next)
                        w_weight_nxt = (r_weight == WEIGHT_LAST) ? 2'd0 : r_weight + 2'd1;
                end
            end
            ST_DONE: begin
                w_paused_nxt = 1'b0;
                if (bus.start_pause) begin
                    w_state_nxt = ST_IDLE;
                    w_load      = 1'b1;
                end else if (bus.tick) begin
                    // Counting the buzzer down to 0 is what ends it.
                    w_dec = 1'b1;
                    if (w_last) w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                if (bus.start_pause) begin
                    w_paused_nxt = !r_paused;
                end else if (bus.tick && !r_paused) begin
                    w_dec       = 1'b1;
                    w_total_nxt = (r_total != 8'd0) ? r_total - 8'd1 : 8'd0;
                    if (w_last) begin
                        case (r_state)
                            ST_FILL:  w_hop = (r_phase == PH_WASH) ? '{st: ST_WASH,  ph: PH_WASH}
                                                                   : '{st: ST_RINSE, ph: PH_RINSE};
                            ST_WASH:  w_hop = '{st: ST_DRAIN, ph: PH_WASH};
                            ST_RINSE: w_hop = '{st: ST_DRAIN, ph: PH_RINSE};
                            // Mask off the segment just finished and everything before it.
                            ST_DRAIN: w_hop = first_seg((r_phase == PH_WASH) ? seg_en_t'(w_en & 3'b110)
                                                                             : seg_en_t'(w_en & 3'b100));
                            default:  w_hop = '{st: ST_DONE, ph: r_phase};
                        endcase
                        w_state_nxt = w_hop.st;
                        w_phase_nxt = w_hop.ph;
                        w_load      = 1'b1;
                        w_load_val  = stage_len(w_hop.st, w_w);
                    end
                end
            end
        endcase
    end

    // Output decode, taken from next state so the registered outputs line up with it.
    always_comb begin
        w_active_nxt     = (w_state_nxt != ST_IDLE) && (w_state_nxt != ST_DONE);
        w_running_nxt    = w_active_nxt && !w_paused_nxt;
        w_valve_in_nxt   = (w_state_nxt == ST_FILL) && !w_paused_nxt;
        w_valve_out_nxt  = ((w_state_nxt == ST_DRAIN) || (w_state_nxt == ST_SPIN)) && !w_paused_nxt;
        w_light_xi_nxt   = ((w_state_nxt == ST_FILL) || (w_state_nxt == ST_WASH) ||
                            (w_state_nxt == ST_DRAIN)) && (w_phase_nxt == PH_WASH);
        w_light_piao_nxt = ((w_state_nxt == ST_FILL) || (w_state_nxt == ST_RINSE) ||
                            (w_state_nxt == ST_DRAIN)) && (w_phase_nxt == PH_RINSE);
        w_light_tuo_nxt  = (w_state_nxt == ST_SPIN);
        w_buzzer_nxt     = (w_state_nxt == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_running    <= 1'b0;
            r_light_xi   <= 1'b0;
            r_light_piao <= 1'b0;
            r_light_tuo  <= 1'b0;
            r_valve_in   <= 1'b0;
            r_valve_out  <= 1'b0;
            r_buzzer     <= 1'b0;
        end else begin
            r_running    <= w_running_nxt;
            r_light_xi   <= w_light_xi_nxt;
            r_light_piao <= w_light_piao_nxt;
            r_light_tuo  <= w_light_tuo_nxt;
            r_valve_in   <= w_valve_in_nxt;
            r_valve_out  <= w_valve_out_nxt;
            r_buzzer     <= w_buzzer_nxt;
        end
    end

    assign bus.running    = r_running;
    assign bus.light_xi   = r_light_xi;
    assign bus.light_piao = r_light_piao;
    assign bus.light_tuo  = r_light_tuo;
    assign bus.valve_in   = r_valve_in;
    assign bus.valve_out  = r_valve_out;
    assign bus.buzzer     = r_buzzer;
    assign bus.mode       = r_mode;
    assign bus.weight     = r_weight;
    assign bus.stage_time = w_stage_time;
    assign bus.total_time = r_total;
endmodule

// File: tb/tb_wash_sequencer.sv
// Purpose: scoreboard bench for wash_sequencer; expectations queued with each stimulus cycle.
// Latency: outputs sampled 1 ns after the edge that follows the stimulus.
// Backpressure: n/a.
`timescale 1ns/1ps
module tb_wash_sequencer;
    import washer_pkg::*;

    localparam int BUZZ = 5;
    localparam int DRN  = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    wash_sequencer_if bus();

    wash_sequencer #(.DRAIN_T(DRN), .BUZZ_T(BUZZ)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef enum int {K_IDLE, K_FILLW, K_WASH, K_DRAINW, K_FILLR, K_RINSE, K_DRAINR, K_SPIN, K_DONE} kind_t;

    typedef struct packed {
        logic       running, xi, piao, tuo, vin, vout, buzz;
        logic [2:0] mode;
        logic [1:0] weight;
        logic [7:0] st, tt;
    } exp_t;

    exp_t  sb_q[$];
    string tag_q[$];
    exp_t  last_e;
    kind_t sk[$];
    int    sl[$];
    int    total;
    int    cur_mode, cur_weight;
    int    errors = 0;
    int    checks = 0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic exp_t mk(input kind_t k, input bit p, input int st, input int tt);
        exp_t e;
        e.running = (k != K_IDLE) && (k != K_DONE) && !p;
        e.xi      = (k == K_FILLW) || (k == K_WASH) || (k == K_DRAINW);
        e.piao    = (k == K_FILLR) || (k == K_RINSE) || (k == K_DRAINR);
        e.tuo     = (k == K_SPIN);
        e.vin     = ((k == K_FILLW) || (k == K_FILLR)) && !p;
        e.vout    = ((k == K_DRAINW) || (k == K_DRAINR) || (k == K_SPIN)) && !p;
        e.buzz    = (k == K_DONE);
        e.mode    = 3'(cur_mode);
        e.weight  = 2'(cur_weight);
        e.st      = 8'(st);
        e.tt      = 8'(tt);
        return e;
    endfunction

    task automatic compare_outputs();
        exp_t  e;
        string t;
        e = sb_q.pop_front();
        t = tag_q.pop_front();
        check_val({t, ".running"},    32'(bus.running),    32'(e.running));
        check_val({t, ".light_xi"},   32'(bus.light_xi),   32'(e.xi));
        check_val({t, ".light_piao"}, 32'(bus.light_piao), 32'(e.piao));
        check_val({t, ".light_tuo"},  32'(bus.light_tuo),  32'(e.tuo));
        check_val({t, ".valve_in"},   32'(bus.valve_in),   32'(e.vin));
        check_val({t, ".valve_out"},  32'(bus.valve_out),  32'(e.vout));
        check_val({t, ".buzzer"},     32'(bus.buzzer),     32'(e.buzz));
        check_val({t, ".mode"},       32'(bus.mode),       32'(e.mode));
        check_val({t, ".weight"},     32'(bus.weight),     32'(e.weight));
        check_val({t, ".stage_time"}, 32'(bus.stage_time), 32'(e.st));
        check_val({t, ".total_time"}, 32'(bus.total_time), 32'(e.tt));
    endtask

    // Compare immediately, without a clock edge (used around asynchronous reset).
    task automatic check_now(input exp_t e, input string tag);
        sb_q.push_back(e);
        tag_q.push_back(tag);
        compare_outputs();
    endtask

    task automatic cyc(input bit t, input bit sp, input bit mn, input bit wn,
                       input exp_t e, input string tag);
        bus.tick        = t;
        bus.start_pause = sp;
        bus.mode_next   = mn;
        bus.weight_next = wn;
        sb_q.push_back(e);
        tag_q.push_back(tag);
        last_e = e;
        @(posedge clk);
        #1;
        bus.tick        = 1'b0;
        bus.start_pause = 1'b0;
        bus.mode_next   = 1'b0;
        bus.weight_next = 1'b0;
        compare_outputs();
    endtask

    task automatic hold();
        cyc(1'b0, 1'b0, 1'b0, 1'b0, last_e, "hold");
    endtask

    task automatic press_mode();
        cur_mode = (cur_mode + 1) % 6;
        cyc(1'b0, 1'b0, 1'b1, 1'b0, mk(K_IDLE, 1'b0, 0, 0), "mode_next");
    endtask

    task automatic press_weight();
        cur_weight = (cur_weight + 1) % 3;
        cyc(1'b0, 1'b0, 1'b0, 1'b1, mk(K_IDLE, 1'b0, 0, 0), "weight_next");
    endtask

    task automatic goto(input int m, input int w);
        while (cur_mode != m)   press_mode();
        while (cur_weight != w) press_weight();
    endtask

    // Expected stage list, expanded straight from the mode descriptions.
    task automatic build(input int m, input int w);
        int wl;
        wl = w + 3;
        sk.delete();
        sl.delete();
        total = 0;
        if (m == 0 || m == 1 || m == 2) begin
            sk.push_back(K_FILLW);  sl.push_back(wl);
            sk.push_back(K_WASH);   sl.push_back(3 * wl);
            sk.push_back(K_DRAINW); sl.push_back(DRN);
        end
        if (m == 0 || m == 2 || m == 3 || m == 4) begin
            sk.push_back(K_FILLR);  sl.push_back(wl);
            sk.push_back(K_RINSE);  sl.push_back(2 * wl);
            sk.push_back(K_DRAINR); sl.push_back(DRN);
        end
        if (m == 0 || m == 3 || m == 5) begin
            sk.push_back(K_SPIN);   sl.push_back(wl);
        end
        foreach (sl[i]) total += sl[i];
    endtask

    task automatic run_from(input int idx, input int st0, input int tt0, input bit abort_done);
        int i;
        int st;
        int tt;
        i  = idx;
        st = st0;
        tt = tt0;
        while (i < sk.size()) begin
            tt--;
            if (st == 1) begin
                i++;
                if (i < sk.size()) st = sl[i];
            end else begin
                st--;
            end
            if (i < sk.size()) cyc(1'b1, 1'b0, 1'b0, 1'b0, mk(sk[i], 1'b0, st, tt), $sformatf("tick_tt%0d", tt));
            else               cyc(1'b1, 1'b0, 1'b0, 1'b0, mk(K_DONE, 1'b0, BUZZ, 0), "done_entry");
            hold();
        end
        for (int b = BUZZ - 1; b >= 0; b--) begin
            if (abort_done && b == BUZZ - 3) begin
                cyc(1'b0, 1'b1, 1'b0, 1'b0, mk(K_IDLE, 1'b0, 0, 0), "done_abort");
                hold();
                return;
            end
            if (b > 0) cyc(1'b1, 1'b0, 1'b0, 1'b0, mk(K_DONE, 1'b0, b, 0), $sformatf("buzz%0d", b));
            else       cyc(1'b1, 1'b0, 1'b0, 1'b0, mk(K_IDLE, 1'b0, 0, 0), "buzz_end");
            hold();
        end
    endtask

    task automatic run_prog(input int m, input int w, input bit abort_done);
        goto(m, w);
        build(m, w);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, mk(sk[0], 1'b0, sl[0], total), $sformatf("start_m%0d_w%0d", m, w));
        hold();
        run_from(0, sl[0], total, abort_done);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.tick        = 1'b0;
        bus.start_pause = 1'b0;
        bus.mode_next   = 1'b0;
        bus.weight_next = 1'b0;
        cur_mode        = 0;
        cur_weight      = 0;

        repeat (3) @(posedge clk);
        #1;
        check_now(mk(K_IDLE, 1'b0, 0, 0), "reset");
        rst = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 1'b0, mk(K_IDLE, 1'b0, 0, 0), "post_reset");

        // Panel keys wrap modulo 6 / 3.
        repeat (7) press_mode();
        repeat (4) press_weight();
        check_val("mode_after_7", 32'(bus.mode), 32'd1);
        check_val("weight_after_4", 32'(bus.weight), 32'd1);

        run_prog(5, 0, 1'b0);   // spin only, shortest program
        run_prog(0, 2, 1'b0);   // full program, total 44
        run_prog(2, 1, 1'b0);
        run_prog(3, 0, 1'b1);   // start_pause ends the buzzer early

        // Pause handling in wash-only mode: FILL3 WASH9 DRAIN2, total 14.
        goto(1, 0);
        build(1, 0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, mk(K_FILLW, 1'b0, 3, 14), "start_m1");
        cyc(1'b1, 1'b1, 1'b0, 1'b0, mk(K_FILLW, 1'b1, 3, 14), "tick_and_pause");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, mk(K_FILLW, 1'b1, 3, 14), "paused_tick_fill");
        cyc(1'b0, 1'b1, 1'b0, 1'b0, mk(K_FILLW, 1'b0, 3, 14), "resume_fill");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, mk(K_FILLW, 1'b0, 2, 13), "fill2");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, mk(K_FILLW, 1'b0, 1, 12), "fill1");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, mk(K_WASH,  1'b0, 9, 11), "wash9");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, mk(K_WASH,  1'b0, 8, 10), "wash8");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, mk(K_WASH,  1'b0, 7, 9),  "wash7");
        cyc(1'b0, 1'b1, 1'b0, 1'b0, mk(K_WASH,  1'b1, 7, 9),  "pause_wash");
        repeat (4) cyc(1'b1, 1'b0, 1'b0, 1'b0, mk(K_WASH, 1'b1, 7, 9), "paused_tick_wash");
        cyc(1'b0, 1'b1, 1'b0, 1'b0, mk(K_WASH,  1'b0, 7, 9),  "resume_wash");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, mk(K_WASH,  1'b0, 6, 8),  "wash6");
        run_from(1, 6, 8, 1'b1);

        // Rinse only: FILL3 RINSE6 DRAIN2, total 11; keys ignored, then async reset.
        goto(4, 0);
        build(4, 0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, mk(K_FILLR, 1'b0, 3, 11), "start_m4");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, mk(K_FILLR, 1'b0, 2, 10), "fillr2");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, mk(K_FILLR, 1'b0, 1, 9),  "fillr1");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, mk(K_RINSE, 1'b0, 6, 8),  "rinse6");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, mk(K_RINSE, 1'b0, 5, 7),  "rinse5");
        cyc(1'b0, 1'b0, 1'b1, 1'b0, mk(K_RINSE, 1'b0, 5, 7),  "mode_next_busy");
        cyc(1'b0, 1'b0, 1'b0, 1'b1, mk(K_RINSE, 1'b0, 5, 7),  "weight_next_busy");
        #2;
        rst = 1'b0;
        #1;
        cur_mode   = 0;
        cur_weight = 0;
        check_now(mk(K_IDLE, 1'b0, 0, 0), "async_reset");
        @(posedge clk);
        #1;
        check_now(mk(K_IDLE, 1'b0, 0, 0), "reset_hold");
        rst = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 1'b0, mk(K_IDLE, 1'b0, 0, 0), "after_release");
        press_mode();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
